// File: rtl/pixel_frame_buffer.sv
// Pixel frame buffer for the VGA display path.
// Port A: processor read/write, port B: display read-only, plus a clear engine
// that fills the whole (draw) page with one value, one pixel per cycle.
// Optional feature macro: FB_DOUBLE_BUFFER_EN adds a draw page and a display
// page that swap only on FRAME_START.
module pixel_frame_buffer #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned X_BITS  = 8,
  parameter int unsigned Y_BITS  = 7
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [X_BITS+Y_BITS-1:0]   A_ADDR,
  input  logic [PIXEL_W-1:0]         A_DATA_IN,
  input  logic                       A_WE,
  output logic                       A_READY,
  output logic [PIXEL_W-1:0]         A_DATA_OUT,
  input  logic [X_BITS+Y_BITS-1:0]   B_ADDR,
  output logic [PIXEL_W-1:0]         B_DATA,
  input  logic                       CLEAR_REQ,
  input  logic [PIXEL_W-1:0]         CLEAR_VALUE,
  output logic                       CLEAR_BUSY
`ifdef FB_DOUBLE_BUFFER_EN
  ,
  input  logic                       FRAME_START,
  input  logic                       SWAP_REQ,
  output logic                       SWAP_PENDING
`endif
);

  // Pixel address width within one page and pixels per page.
  localparam int unsigned AddrW = X_BITS + Y_BITS;
  localparam int unsigned Depth = 1 << AddrW;

`ifdef FB_DOUBLE_BUFFER_EN
  // The page bit is prepended to every pixel address.
  localparam int unsigned MemAddrW = AddrW + 1;
`else
  localparam int unsigned MemAddrW = AddrW;
`endif
  localparam int unsigned MemDepth = 1 << MemAddrW;

  typedef enum logic {
    StIdle,
    StClear
  } clr_state_e;

  clr_state_e state_q, state_d;
  logic [AddrW-1:0]   cnt_q, cnt_d;
  logic [PIXEL_W-1:0] clr_val_q, clr_val_d;

  logic                clear_busy;
  logic                a_wr_acc;
  logic                clr_wr;
  logic                mem_we;
  logic [MemAddrW-1:0] mem_waddr;
  logic [PIXEL_W-1:0]  mem_wdata;

  logic [MemAddrW-1:0] a_mem_addr;
  logic [MemAddrW-1:0] b_mem_addr;
  logic [MemAddrW-1:0] clr_mem_addr;

  logic [PIXEL_W-1:0]  a_rdata_q;
  logic [PIXEL_W-1:0]  b_rdata_q;

  logic [PIXEL_W-1:0]  mem [MemDepth];

  // Busy comes straight from the state register, so it is already registered.
  assign clear_busy = (state_q == StClear);
  assign CLEAR_BUSY = clear_busy;
  assign A_READY    = ~clear_busy;

  //--------------------------------------------------------------------------
  // Page selection
  //--------------------------------------------------------------------------
`ifdef FB_DOUBLE_BUFFER_EN
  logic draw_page_q, draw_page_d;
  logic disp_page_q, disp_page_d;
  logic swap_pending_q, swap_pending_d;
  logic do_swap;

  // A request arriving with FRAME_START is only recorded; it swaps at the
  // following frame. A swap never happens mid-clear.
  assign do_swap = FRAME_START & swap_pending_q & ~clear_busy & ~SWAP_REQ;

  // Next-state for page bits and the pending flag.
  always_comb begin
    draw_page_d    = draw_page_q;
    disp_page_d    = disp_page_q;
    swap_pending_d = swap_pending_q;
    if (SWAP_REQ) begin
      swap_pending_d = 1'b1;
    end else if (do_swap) begin
      swap_pending_d = 1'b0;
      draw_page_d    = ~draw_page_q;
      disp_page_d    = ~disp_page_q;
    end
  end

  // Page state registers; draw starts on page 1, display on page 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      draw_page_q    <= 1'b1;
      disp_page_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      draw_page_q    <= draw_page_d;
      disp_page_q    <= disp_page_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign SWAP_PENDING = swap_pending_q;
  assign a_mem_addr   = {draw_page_q, A_ADDR};
  assign b_mem_addr   = {disp_page_q, B_ADDR};
  assign clr_mem_addr = {draw_page_q, cnt_q};
`else
  assign a_mem_addr   = A_ADDR;
  assign b_mem_addr   = B_ADDR;
  assign clr_mem_addr = cnt_q;
`endif

  //--------------------------------------------------------------------------
  // Clear engine
  //--------------------------------------------------------------------------

  // Next-state logic: latch the fill value on entry, walk every address once.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_val_d = clr_val_q;
    unique case (state_q)
      StIdle: begin
        if (CLEAR_REQ) begin
          state_d   = StClear;
          cnt_d     = '0;
          clr_val_d = CLEAR_VALUE;
        end
      end
      StClear: begin
        // Counter wraps to zero after the last pixel; no carry is kept.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AddrW{1'b1}}) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Clear engine state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      clr_val_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_val_q <= clr_val_d;
    end
  end

  //--------------------------------------------------------------------------
  // Single write port shared by port A and the clear engine
  //--------------------------------------------------------------------------

  // Port A is locked out while clearing, so the two sources never collide.
  // A reset edge aborts the clear without writing the current pixel.
  assign a_wr_acc = A_WE & ~clear_busy;
  assign clr_wr   = clear_busy & ~RESET;

  // Write mux: clear engine takes the port whenever it is running.
  always_comb begin
    mem_we    = a_wr_acc | clr_wr;
    mem_waddr = a_mem_addr;
    mem_wdata = A_DATA_IN;
    if (clr_wr) begin
      mem_waddr = clr_mem_addr;
      mem_wdata = clr_val_q;
    end
  end

  // Pixel memory write; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered reads on both ports; a same-edge write returns the old pixel.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= mem[a_mem_addr];
      b_rdata_q <= mem[b_mem_addr];
    end
  end

  assign A_DATA_OUT = a_rdata_q;
  assign B_DATA     = b_rdata_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Self-checking bench for pixel_frame_buffer (default parameters).
module tb_pixel_frame_buffer;

  localparam int unsigned PW    = 8;
  localparam int unsigned AW    = 15;
  localparam int unsigned DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [AW-1:0] A_ADDR;
  logic [PW-1:0] A_DATA_IN;
  logic          A_WE;
  logic          A_READY;
  logic [PW-1:0] A_DATA_OUT;
  logic [AW-1:0] B_ADDR;
  logic [PW-1:0] B_DATA;
  logic          CLEAR_REQ;
  logic [PW-1:0] CLEAR_VALUE;
  logic          CLEAR_BUSY;
`ifdef FB_DOUBLE_BUFFER_EN
  logic          FRAME_START;
  logic          SWAP_REQ;
  logic          SWAP_PENDING;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pixel_frame_buffer #(
    .PIXEL_W (8),
    .X_BITS  (8),
    .Y_BITS  (7)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .A_ADDR      (A_ADDR),
    .A_DATA_IN   (A_DATA_IN),
    .A_WE        (A_WE),
    .A_READY     (A_READY),
    .A_DATA_OUT  (A_DATA_OUT),
    .B_ADDR      (B_ADDR),
    .B_DATA      (B_DATA),
    .CLEAR_REQ   (CLEAR_REQ),
    .CLEAR_VALUE (CLEAR_VALUE),
    .CLEAR_BUSY  (CLEAR_BUSY)
`ifdef FB_DOUBLE_BUFFER_EN
    ,
    .FRAME_START  (FRAME_START),
    .SWAP_REQ     (SWAP_REQ),
    .SWAP_PENDING (SWAP_PENDING)
`endif
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [PW-1:0] d;
    logic [AW-1:0] b;
    logic          ca;
    logic [PW-1:0] ea;
    logic          cb;
    logic [PW-1:0] eb;
  } vec_t;

  vec_t vt[7];

  // Reference memory: last value written per address, plus a written flag.
  logic [PW-1:0] model [DEPTH];
  bit            valid [DEPTH];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic write_a(input logic [AW-1:0] addr, input logic [PW-1:0] data);
    A_ADDR    = addr;
    A_DATA_IN = data;
    A_WE      = 1'b1;
    tick();
    A_WE      = 1'b0;
  endtask

  task automatic read_a(input logic [AW-1:0] addr, output logic [PW-1:0] data);
    A_ADDR = addr;
    A_WE   = 1'b0;
    tick();
    data = A_DATA_OUT;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] rd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          rwe;
    logic [PW-1:0] rdin;
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    bit            va;
    bit            vb;
    int            n;
    logic [AW-1:0] sweep [5];

    RESET       = 1'b1;
    A_ADDR      = '0;
    A_DATA_IN   = '0;
    A_WE        = 1'b0;
    B_ADDR      = '0;
    CLEAR_REQ   = 1'b0;
    CLEAR_VALUE = '0;
`ifdef FB_DOUBLE_BUFFER_EN
    FRAME_START = 1'b0;
    SWAP_REQ    = 1'b0;
`endif
    tick();
    tick();
    check("rst_a_data_out", A_DATA_OUT, 0);
    check("rst_b_data", B_DATA, 0);
    check("rst_clear_busy", CLEAR_BUSY, 0);
    check("rst_a_ready", A_READY, 1);
`ifdef FB_DOUBLE_BUFFER_EN
    check("rst_swap_pending", SWAP_PENDING, 0);
`endif
    RESET = 1'b0;
    tick();

`ifndef FB_DOUBLE_BUFFER_EN
    // Directed vectors: outputs after each edge reflect reads at that edge.
    vt[0] = '{1'b1, 15'h0010, 8'h00, 15'h0010, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[1] = '{1'b1, 15'h0010, 8'h3C, 15'h0010, 1'b1, 8'h00, 1'b1, 8'h00};
    vt[2] = '{1'b1, 15'h1234, 8'hA5, 15'h0010, 1'b0, 8'h00, 1'b1, 8'h3C};
    vt[3] = '{1'b0, 15'h1234, 8'h00, 15'h1234, 1'b1, 8'hA5, 1'b1, 8'hA5};
    vt[4] = '{1'b0, 15'h0010, 8'h00, 15'h1234, 1'b1, 8'h3C, 1'b1, 8'hA5};
    vt[5] = '{1'b1, 15'h7FFF, 8'hFF, 15'h0010, 1'b0, 8'h00, 1'b1, 8'h3C};
    vt[6] = '{1'b0, 15'h7FFF, 8'h00, 15'h7FFF, 1'b1, 8'hFF, 1'b1, 8'hFF};
    for (int i = 0; i < 7; i++) begin
      A_WE      = vt[i].we;
      A_ADDR    = vt[i].a;
      A_DATA_IN = vt[i].d;
      B_ADDR    = vt[i].b;
      tick();
      if (vt[i].ca) check($sformatf("vec%0d_a", i), A_DATA_OUT, vt[i].ea);
      if (vt[i].cb) check($sformatf("vec%0d_b", i), B_DATA, vt[i].eb);
      if (vt[i].we) begin
        model[vt[i].a] = vt[i].d;
        valid[vt[i].a] = 1'b1;
      end
    end
    A_WE = 1'b0;

    // Random traffic on both ports against the reference memory.
    for (int i = 0; i < 400; i++) begin
      ra   = AW'($urandom_range(0, 63) * 509);
      rb   = AW'($urandom_range(0, 63) * 509);
      rwe  = 1'($urandom_range(0, 1));
      rdin = PW'($urandom);
      ea   = model[ra];
      va   = valid[ra];
      eb   = model[rb];
      vb   = valid[rb];
      A_ADDR    = ra;
      B_ADDR    = rb;
      A_WE      = rwe;
      A_DATA_IN = rdin;
      tick();
      if (va) check($sformatf("rand%0d_a", i), A_DATA_OUT, ea);
      if (vb) check($sformatf("rand%0d_b", i), B_DATA, eb);
      if (rwe) begin
        model[ra] = rdin;
        valid[ra] = 1'b1;
      end
    end
    A_WE = 1'b0;
`endif

    // Full clear with 0x7E; a same-cycle write is accepted then overwritten.
    CLEAR_VALUE = 8'h7E;
    CLEAR_REQ   = 1'b1;
    A_ADDR      = 15'h0005;
    A_DATA_IN   = 8'h99;
    A_WE        = 1'b1;
    check("ready_at_req", A_READY, 1);
    tick();
    CLEAR_REQ = 1'b0;
    A_WE      = 1'b0;
    check("busy_after_req", CLEAR_BUSY, 1);
    check("ready_low_in_clear", A_READY, 0);
    n = 0;
    while (CLEAR_BUSY === 1'b1 && n < 40000) begin
      n++;
      // Write to an already-cleared pixel must be dropped.
      A_WE      = (n == 10);
      A_ADDR    = 15'h0003;
      A_DATA_IN = 8'h22;
      if (n == 10) check("ready_mid_clear", A_READY, 0);
      // Second request mid-clear must be ignored.
      CLEAR_REQ   = (n == 20);
      CLEAR_VALUE = (n == 20) ? 8'h11 : 8'h7E;
      tick();
    end
    A_WE      = 1'b0;
    CLEAR_REQ = 1'b0;
    check("busy_cycles", n, DEPTH);
    check("ready_after_clear", A_READY, 1);
    sweep[0] = 15'h0000;
    sweep[1] = 15'h4000;
    sweep[2] = 15'h7FFF;
    sweep[3] = 15'h0003;
    sweep[4] = 15'h0005;
    for (int i = 0; i < 5; i++) begin
      read_a(sweep[i], rd);
      check($sformatf("clear_pt_%0h", sweep[i]), rd, 8'h7E);
    end
    for (int i = 0; i < 128; i++) begin
      read_a(AW'(i * 256 + 255), rd);
      check($sformatf("clear_sweep_%0d", i), rd, 8'h7E);
    end

    // Reset 100 writes into a clear: pixels 0..0x63 cleared, 0x64 untouched.
    write_a(15'h0063, 8'hC3);
    write_a(15'h0064, 8'hC3);
    write_a(15'h0000, 8'hC3);
    CLEAR_VALUE = 8'h5A;
    CLEAR_REQ   = 1'b1;
    A_ADDR      = 15'h0063;
    B_ADDR      = 15'h0063;
    tick();
    CLEAR_REQ = 1'b0;
    repeat (100) tick();
    RESET = 1'b1;
    tick();
    check("abort_busy", CLEAR_BUSY, 0);
    check("abort_a_data_out", A_DATA_OUT, 0);
    check("abort_b_data", B_DATA, 0);
    RESET = 1'b0;
    read_a(15'h0063, rd);
    check("abort_0063", rd, 8'h5A);
    read_a(15'h0064, rd);
    check("abort_0064", rd, 8'hC3);
    read_a(15'h0000, rd);
    check("abort_0000", rd, 8'h5A);
    check("abort_ready", A_READY, 1);

`ifdef FB_DOUBLE_BUFFER_EN
    // Pages after reset: draw 1, display 0.
    write_a(15'h0123, 8'h66);
    B_ADDR      = 15'h0123;
    SWAP_REQ    = 1'b1;
    FRAME_START = 1'b1;
    tick();
    SWAP_REQ    = 1'b0;
    FRAME_START = 1'b0;
    check("db_same_cycle_pending", SWAP_PENDING, 1);
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    check("db_swap1_pending", SWAP_PENDING, 0);
    tick();
    check("db_swap1_b", B_DATA, 8'h66);
    // Draw page is now 0.
    write_a(15'h0123, 8'h55);
    SWAP_REQ = 1'b1;
    tick();
    SWAP_REQ = 1'b0;
    check("db_pending_set", SWAP_PENDING, 1);
    tick();
    check("db_b_old_page", B_DATA, 8'h66);
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    check("db_swap2_pending", SWAP_PENDING, 0);
    tick();
    check("db_swap2_b", B_DATA, 8'h55);
    read_a(15'h0123, rd);
    check("db_swap2_a", rd, 8'h66);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
